// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state codes, opcodes,
// fault cause codes and the fetch-address legality check.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [5:0]  OP_J           = 6'h02;
  localparam logic [5:0]  OP_JAL         = 6'h03;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_RANGE    = 2'b10;

  localparam logic [31:0] NOP            = 32'h0000_0000;

  // 33-bit address so that a pc+4 carry out of bit 31 lands in the range check
  function automatic logic [1:0] fetch_addr_check(input logic [32:0] addr,
                                                  input logic [32:0] limit);
    if (addr[1:0] != 2'b00) return FAULT_MISALIGN;
    if (addr >= limit)      return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, redirect input and IF/ID handshake.
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4
  );
endinterface

// File: rtl/fetch_stage_next_pc.sv
// Next-PC selection with fault classification of the candidate PC.
module fetch_next_pc
  import cpu_defs_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        load,
  input  logic [32:0] range_limit,
  output logic [31:0] next_pc,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  logic [32:0] cand;

  always_comb begin
    cand = {1'b0, pc};
    if (redirect_valid)
      cand = {1'b0, redirect_target};
    else if (load)
      cand = {1'b0, pc} + 33'd4;

    fault_cause = FAULT_NONE;
    if (redirect_valid || load)
      fault_cause = fetch_addr_check(cand, range_limit);

    fault_addr = cand[31:0];
    // a faulting candidate never reaches the PC
    next_pc    = (fault_cause == FAULT_NONE) ? cand[31:0] : pc;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC owner, IF/ID output register, halt/fault FSM
// and handoff counter.
//
//   state | meaning
//   BOOT  | first cycle after reset, RESET_PC checked
//   RUN   | fetching, one instruction per cycle when downstream is ready
//   HALT  | self-loop j handed off, fetch stopped until reset
//   FAULT | illegal fetch address seen, fetch stopped until reset
module fetch_stage
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_WORDS  = 256,
  parameter bit          HALT_DETECT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     fif,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  localparam logic [1:0]  ST_BOOT     = BOOT;
  localparam logic [1:0]  ST_RUN      = RUN;
  localparam logic [1:0]  ST_HALT     = HALT;
  localparam logic [1:0]  ST_FAULT    = FAULT;

  localparam logic [32:0] RANGE_LIMIT = 33'(IMEM_WORDS) << 2;
  localparam logic [1:0]  BOOT_CAUSE  = fetch_addr_check({1'b0, RESET_PC}, RANGE_LIMIT);

  logic [1:0]  state;
  logic [31:0] pc;
  logic        halt_pend;
  logic        handoff;
  logic        redir;
  logic        load;
  logic        halt_hit;
  logic [31:0] nxt_pc;
  logic [1:0]  nxt_cause;
  logic [31:0] nxt_addr;

  assign fif.imem_addr = pc;
  assign handoff       = fif.out_valid & fif.out_ready;
  assign redir         = (state == ST_RUN) & fif.redirect_valid;
  // once the halt idiom is in the output register nothing further is loaded
  assign load          = (state == ST_RUN) & (~fif.out_valid | fif.out_ready)
                         & ~fif.redirect_valid & ~halt_pend;
  assign halt_hit      = HALT_DETECT
                         && (fif.imem_rdata[31:26] == OP_J)
                         && (fif.imem_rdata[25:0] == pc[27:2]);

  assign halted = (state == ST_HALT);
  assign fault  = (state == ST_FAULT);

  fetch_next_pc u_next_pc (
    .pc              (pc),
    .redirect_valid  (redir),
    .redirect_target (fif.redirect_target),
    .load            (load),
    .range_limit     (RANGE_LIMIT),
    .next_pc         (nxt_pc),
    .fault_cause     (nxt_cause),
    .fault_addr      (nxt_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_BOOT;
      pc               <= RESET_PC;
      halt_pend        <= 1'b0;
      fif.out_valid    <= 1'b0;
      fif.out_instr    <= NOP;
      fif.out_pc       <= 32'h0;
      fif.out_pc_plus4 <= 32'h0;
      fault_cause      <= FAULT_NONE;
      fault_addr       <= 32'h0;
      fetch_count      <= 32'h0;
    end else begin
      if (handoff)
        fetch_count <= fetch_count + 32'd1;

      case (state)
        ST_BOOT: begin
          if (BOOT_CAUSE != FAULT_NONE) begin
            state       <= ST_FAULT;
            fault_cause <= BOOT_CAUSE;
            fault_addr  <= RESET_PC;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (nxt_cause != FAULT_NONE) begin
            state         <= ST_FAULT;
            fault_cause   <= nxt_cause;
            fault_addr    <= nxt_addr;
            fif.out_valid <= 1'b0;
            halt_pend     <= 1'b0;
          end else if (redir) begin
            pc            <= nxt_pc;
            fif.out_valid <= 1'b0;
            halt_pend     <= 1'b0;
          end else if (halt_pend) begin
            if (handoff) begin
              state         <= ST_HALT;
              fif.out_valid <= 1'b0;
              halt_pend     <= 1'b0;
            end
          end else if (load) begin
            fif.out_instr    <= fif.imem_rdata;
            fif.out_pc       <= pc;
            fif.out_pc_plus4 <= pc + 32'd4;
            fif.out_valid    <= 1'b1;
            pc               <= nxt_pc;
            halt_pend        <= halt_hit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// redirect/backpressure traffic against a behavioural model.
module tb_fetch_stage;

  localparam int          IMEM_WORDS = 256;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if bif();

  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:IMEM_WORDS-1];
  assign bif.imem_rdata = mem[bif.imem_addr[9:2]];

  fetch_stage #(
    .RESET_PC    (RESET_PC),
    .IMEM_WORDS  (IMEM_WORDS),
    .HALT_DETECT (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fif         (bif.master),
    .halted      (halted),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr),
    .fetch_count (fetch_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // behavioural model
  int          m_state;
  logic [31:0] m_pc, m_instr, m_opc, m_cnt, m_faddr;
  logic        m_valid, m_hpend;
  logic [1:0]  m_cause;

  function automatic logic [1:0] addr_fault(input longint a);
    if (a % 4 != 0) return 2'b01;
    if (a >= longint'(IMEM_WORDS) * 4) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic is_halt(input logic [31:0] word, input logic [31:0] addr);
    logic [31:0] tgt_word;
    tgt_word = addr >> 2;
    return (word[31:26] == 6'h02) && (word[25:0] == tgt_word[25:0]);
  endfunction

  task automatic model_reset();
    m_state = M_BOOT;
    m_pc    = RESET_PC;
    m_instr = 32'h0;
    m_opc   = 32'h0;
    m_cnt   = 32'h0;
    m_faddr = 32'h0;
    m_valid = 1'b0;
    m_hpend = 1'b0;
    m_cause = 2'b00;
  endtask

  task automatic go_fault(input logic [1:0] c, input logic [31:0] a);
    m_state = M_FAULT;
    m_cause = c;
    m_faddr = a;
    m_valid = 1'b0;
    m_hpend = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rt, input logic rdy);
    logic       hand;
    longint     nxt;
    logic [1:0] c;
    hand = m_valid && rdy;
    if (hand) m_cnt = m_cnt + 32'd1;
    case (m_state)
      M_BOOT: begin
        c = addr_fault(longint'(RESET_PC));
        if (c != 2'b00) go_fault(c, RESET_PC);
        else m_state = M_RUN;
      end
      M_RUN: begin
        if (rv) begin
          c = addr_fault(longint'(rt));
          if (c != 2'b00) go_fault(c, rt);
          else begin
            m_pc    = rt;
            m_valid = 1'b0;
            m_hpend = 1'b0;
          end
        end else if (m_hpend) begin
          if (hand) begin
            m_state = M_HALT;
            m_valid = 1'b0;
          end
        end else if (!m_valid || rdy) begin
          nxt = longint'(m_pc) + 4;
          c   = addr_fault(nxt);
          if (c != 2'b00) go_fault(c, nxt[31:0]);
          else begin
            m_instr = mem[m_pc >> 2];
            m_opc   = m_pc;
            m_valid = 1'b1;
            m_hpend = is_halt(m_instr, m_pc);
            m_pc    = nxt[31:0];
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("imem_addr", bif.imem_addr, m_pc);
    chk("out_valid", 32'(bif.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_pc", bif.out_pc, m_opc);
      chk("out_instr", bif.out_instr, m_instr);
      chk("out_pc_plus4", bif.out_pc_plus4, m_opc + 32'd4);
    end
    chk("halted", 32'(halted), 32'(m_state == M_HALT));
    chk("fault", 32'(fault), 32'(m_state == M_FAULT));
    chk("fault_cause", 32'(fault_cause), 32'(m_cause));
    chk("fault_addr", fault_addr, m_faddr);
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic cyc(input logic rv, input logic [31:0] rt, input logic rdy);
    bif.redirect_valid  = rv;
    bif.redirect_target = rt;
    bif.out_ready       = rdy;
    @(posedge clk);
    model_step(rv, rt, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    bif.redirect_valid  = 1'b0;
    bif.redirect_target = 32'h0;
    bif.out_ready       = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("rst_out_instr", bif.out_instr, 32'h0);
    chk("rst_out_pc", bif.out_pc, 32'h0);
    chk("rst_out_pc_plus4", bif.out_pc_plus4, 32'h0);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < IMEM_WORDS; i++) begin
      w = $urandom;
      if (w[31:26] == 6'h02) w[31:26] = 6'h03;
      mem[i] = w;
    end
    mem[14] = 32'h0800_000E;
    mem[40] = {6'h02, 26'd40};
    mem[50] = {6'h03, 26'd50};

    bif.redirect_valid  = 1'b0;
    bif.redirect_target = 32'h0;
    bif.out_ready       = 1'b0;

    // sequential fetch from reset
    do_reset();
    cyc(1'b0, 32'h0, 1'b1);
    chk("t1_boot_valid", 32'(bif.out_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t1_first_valid", 32'(bif.out_valid), 32'd1);
    chk("t1_pc0", bif.out_pc, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 32'h0, 1'b1);
      chk("t1_pc_seq", bif.out_pc, 32'(k * 4));
    end
    cyc(1'b0, 32'h0, 1'b1);
    chk("t1_count", fetch_count, 32'd5);

    // stall at 0x8, then redirect, then halt
    do_reset();
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t2_pc8", bif.out_pc, 32'h8);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'h0, 1'b0);
      chk("t2_stall_pc", bif.out_pc, 32'h8);
      chk("t2_stall_addr", bif.imem_addr, 32'hC);
      chk("t2_stall_count", fetch_count, 32'd2);
    end
    cyc(1'b0, 32'h0, 1'b1);
    chk("t2_release_count", fetch_count, 32'd3);
    chk("t2_release_pc", bif.out_pc, 32'hC);
    for (int k = 0; k < 4; k++) cyc(1'b0, 32'h0, 1'b1);
    chk("t3_pc1c", bif.out_pc, 32'h1C);
    cyc(1'b1, 32'h24, 1'b1);
    chk("t3_flush_valid", 32'(bif.out_valid), 32'd0);
    chk("t3_count", fetch_count, 32'd8);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t3_pc24", bif.out_pc, 32'h24);
    for (int k = 0; k < 5; k++) cyc(1'b0, 32'h0, 1'b1);
    chk("t4_pc38", bif.out_pc, 32'h38);
    cyc(1'b0, 32'h0, 1'b1);
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_valid", 32'(bif.out_valid), 32'd0);
    chk("t4_count", fetch_count, 32'd14);
    cyc(1'b1, 32'h0, 1'b1);
    chk("t4_redir_ignored", 32'(halted), 32'd1);
    chk("t4_addr_held", bif.imem_addr, 32'h3C);

    // faults
    do_reset();
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h32, 1'b1);
    chk("t5_mis_fault", 32'(fault), 32'd1);
    chk("t5_mis_cause", 32'(fault_cause), 32'd1);
    chk("t5_mis_addr", fault_addr, 32'h32);
    do_reset();
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h400, 1'b1);
    chk("t5_rng_cause", 32'(fault_cause), 32'd2);
    chk("t5_rng_addr", fault_addr, 32'h400);

    // async reset in the middle of a stall
    do_reset();
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    chk("t6_valid_before", 32'(bif.out_valid), 32'd1);
    #2;
    do_reset();

    // randomized traffic
    for (int ep = 0; ep < 6; ep++) begin
      logic        rv, rdy;
      logic [31:0] rt;
      int          sel;
      do_reset();
      for (int i = 0; i < 200; i++) begin
        rv  = ($urandom_range(0, 99) < 8);
        rdy = ($urandom_range(0, 99) < 70);
        sel = int'($urandom_range(0, 99));
        if (sel < 70)      rt = 32'($urandom_range(0, 255)) << 2;
        else if (sel < 80) rt = 32'h38 + (32'($urandom_range(0, 3)) << 2);
        else if (sel < 86) rt = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        else if (sel < 94) rt = 32'h3E0 + (32'($urandom_range(0, 7)) << 2);
        else if (sel < 97) rt = 32'($urandom_range(256, 4096)) << 2;
        else               rt = 32'hFFFF_FFFC;
        cyc(rv, rt, rdy);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
